// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch front end. Owns the fetch PC, issues
// sequential word reads to a one-cycle-latency instruction memory, queues
// returned {pc, inst} pairs in a small FIFO and hands the head entry to
// decode over valid/ready. A redirect flushes the queue, drops the
// in-flight read and restarts fetch at the target.
module fetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h01000000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      redirect_valid,
   input  logic [31:0]               redirect_pc,
   output logic                      imem_req,
   output logic [31:0]               imem_addr,
   input  logic [31:0]               imem_data,
   output logic                      dec_valid,
   input  logic                      dec_ready,
   output logic [31:0]               dec_pc,
   output logic [31:0]               dec_inst,
   output logic [$clog2(DEPTH):0]    occupancy
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam logic [31:0] NOP = 32'h00000013;

   logic [31:0]   fetch_pc_q,    fetch_pc_d;
   logic          inflight_q,    inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic [PW-1:0] rd_ptr_q,      rd_ptr_d;
   logic [PW-1:0] wr_ptr_q,      wr_ptr_d;
   logic [CW-1:0] count_q,       count_d;
   logic [31:0]   hold_pc_q,     hold_pc_d;
   logic [31:0]   hold_inst_q,   hold_inst_d;

   logic [31:0]   slot_pc_q   [DEPTH];
   logic [31:0]   slot_inst_q [DEPTH];

   logic          pop;
   logic          push;
   logic          issue;
   logic          wr_en;
   logic [CW:0]   level;
   logic [31:0]   head_pc;
   logic [31:0]   head_inst;

   // Handshake, issue decision and decode-facing outputs.
   always_comb begin
      head_pc   = slot_pc_q[rd_ptr_q];
      head_inst = slot_inst_q[rd_ptr_q];
      dec_valid = (count_q != '0);
      pop       = dec_valid & dec_ready;
      // Entries held plus the read in flight, minus what leaves this cycle.
      level     = {1'b0, count_q}
                + {{CW{1'b0}}, inflight_q}
                - {{CW{1'b0}}, pop};
      issue     = reset & ~redirect_valid & (level < (CW+1)'(DEPTH));
      push      = inflight_q & ~redirect_valid;
      wr_en     = push & reset;
      imem_req  = issue;
      imem_addr = fetch_pc_q;
      // With the queue empty, decode keeps seeing the last presented entry.
      dec_pc    = dec_valid ? head_pc   : hold_pc_q;
      dec_inst  = dec_valid ? head_inst : hold_inst_q;
      occupancy = count_q;
   end

   // Next-state logic for PC, in-flight tracking and FIFO bookkeeping.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      hold_pc_d     = dec_valid ? head_pc   : hold_pc_q;
      hold_inst_d   = dec_valid ? head_inst : hold_inst_q;

      if (redirect_valid) begin
         // A same-cycle pop still reaches decode; everything behind it is flushed.
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
         inflight_d = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (issue) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= RESET_PC;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         hold_pc_q     <= RESET_PC;
         hold_inst_q   <= NOP;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         hold_pc_q     <= hold_pc_d;
         hold_inst_q   <= hold_inst_d;
      end
   end

   // FIFO storage; returned word paired with the PC that requested it.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         slot_pc_q[wr_ptr_q]   <= inflight_pc_q;
         slot_inst_q[wr_ptr_q] <= imem_data;
      end
   end

endmodule
